// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage buffer: occupancy states,
// default widths and bit positions inside the control bundle.
package pipe_pkg;

   localparam int DEFAULT_DATA_W = 160;
   localparam int DEFAULT_CTRL_W = 16;

   localparam int CTRL_REGWRITE  = 0;
   localparam int CTRL_MEMREAD   = 1;
   localparam int CTRL_MEMWRITE  = 2;
   localparam int CTRL_BRANCH    = 3;
   localparam int CTRL_ALUOP_LSB = 4;
   localparam int CTRL_ALUOP_W   = 2;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the stage buffer: a load-enabled register
// that clears synchronously on reset.
module pipe_slot #(
   parameter int W = 176
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] slot_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         slot_q <= '0;
      end else if (load_i) begin
         slot_q <= d_i;
      end
   end

   assign q_o = slot_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register with a 2-entry skid buffer and flush.
// Define PIPE_STAGE_PERF_CNT_EN to add saturating stall/bubble counters.
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int                DATA_W       = DEFAULT_DATA_W,
   parameter int                CTRL_W       = DEFAULT_CTRL_W,
   parameter logic [CTRL_W-1:0] CTRL_RST_VAL = {CTRL_W{1'b0}}
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_CNT_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       bubble_cnt
`endif
);

   localparam int SLOT_W = DATA_W + CTRL_W;
   localparam int MAIN   = 0;
   localparam int SKID   = 1;

   state_e            state_q, state_d;
   logic              in_ready_q;
   logic              accept, pop;
   logic              main_from_skid;
   logic [1:0]        slot_load;
   logic [SLOT_W-1:0] slot_d [2];
   logic [SLOT_W-1:0] slot_q [2];

   assign accept = in_valid & in_ready_q;
   assign pop    = out_valid & out_ready;

   always_comb begin
      state_d        = state_q;
      slot_load      = 2'b00;
      main_from_skid = 1'b0;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d         = ONE;
               slot_load[MAIN] = 1'b1;
            end
         end
         ONE: begin
            if (accept && pop) begin
               slot_load[MAIN] = 1'b1;
            end else if (accept) begin
               state_d         = TWO;
               slot_load[SKID] = 1'b1;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            // in_ready is low here, so only the skid entry can move.
            if (pop) begin
               state_d         = ONE;
               slot_load[MAIN] = 1'b1;
               main_from_skid  = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (flush) begin
         state_d   = EMPTY;
         slot_load = 2'b00;
      end
   end

   assign slot_d[MAIN] = main_from_skid ? slot_q[SKID] : {in_data, in_ctrl};
   assign slot_d[SKID] = {in_data, in_ctrl};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : gen_slot
         pipe_slot #(.W(SLOT_W)) u_slot (
            .clk    (clk),
            .reset  (reset),
            .load_i (slot_load[gi]),
            .d_i    (slot_d[gi]),
            .q_o    (slot_q[gi])
         );
      end
   endgenerate

   // in_ready is a flop of the next-state decode, never a comb path from out_ready.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != TWO);
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != EMPTY);
   assign out_data  = slot_q[MAIN][SLOT_W-1:CTRL_W];
   assign out_ctrl  = out_valid ? slot_q[MAIN][CTRL_W-1:0] : CTRL_RST_VAL;
   assign occupancy = state_q;

`ifdef PIPE_STAGE_PERF_CNT_EN
   logic [31:0] stall_cnt_q, bubble_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (!out_valid && out_ready && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
         end
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: vector table, streaming, randomized traffic
// against a queue scoreboard; counters checked when PIPE_STAGE_PERF_CNT_EN is set.
module tb_pipe_stage_buf;
   import pipe_pkg::*;

   localparam int DW = 32;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b0, flush = 1'b0;
   logic          in_valid = 1'b0, in_ready;
   logic [DW-1:0] in_data = '0;
   logic [CW-1:0] in_ctrl = '0;
   logic          out_valid, out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
   logic [1:0]    occupancy;
`ifdef PIPE_STAGE_PERF_CNT_EN
   logic [31:0]   stall_cnt, bubble_cnt;
   logic [31:0]   m_stall = '0, m_bubble = '0;
`endif

   always #5 clk = ~clk;

   pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST_VAL(16'h0000)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl),
      .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_CNT_EN
      ,
      .stall_cnt (stall_cnt),
      .bubble_cnt(bubble_cnt)
`endif
   );

   typedef struct packed {
      logic [DW-1:0] d;
      logic [CW-1:0] c;
   } ent_t;

   typedef struct {
      logic          rst, fl, iv, ordy;
      logic [DW-1:0] d;
      logic [CW-1:0] c;
      logic [1:0]    occ;
      logic          irdy, ov, chk_d;
      logic [DW-1:0] od;
      logic [CW-1:0] oc;
   } vec_t;

   ent_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_state();
      chk("occupancy", {30'd0, occupancy}, sb.size());
      chk("in_ready", {31'd0, in_ready}, {31'd0, sb.size() != 2});
      chk("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
      if (sb.size() == 0) begin
         chk("out_ctrl_idle", {16'd0, out_ctrl}, 32'd0);
      end else begin
         chk("out_data_head", out_data, sb[0].d);
         chk("out_ctrl_head", {16'd0, out_ctrl}, {16'd0, sb[0].c});
      end
   endtask

   // Drive one cycle, advance the reference queue, then check after the edge.
   task automatic step(input logic r, input logic f, input logic iv, input logic ordy,
                       input logic [DW-1:0] d, input logic [CW-1:0] c);
      logic acc, pp;
      reset = r; flush = f; in_valid = iv; out_ready = ordy; in_data = d; in_ctrl = c;
      acc = iv && (sb.size() != 2);
      pp  = (sb.size() != 0) && ordy;
`ifdef PIPE_STAGE_PERF_CNT_EN
      if (r) begin
         m_stall = '0; m_bubble = '0;
      end else begin
         if (sb.size() != 0 && !ordy && m_stall != 32'hFFFF_FFFF) m_stall++;
         if (sb.size() == 0 && ordy && m_bubble != 32'hFFFF_FFFF) m_bubble++;
      end
`endif
      if (r || f) begin
         sb.delete();
      end else begin
         if (pp) void'(sb.pop_front());
         if (acc) sb.push_back('{d: d, c: c});
      end
      @(posedge clk);
      #1;
      check_state();
   endtask

   localparam logic [CW-1:0] C_MW = 16'(1) << CTRL_MEMWRITE;
   localparam logic [CW-1:0] C_LD = (16'(1) << CTRL_MEMREAD) | (16'(1) << CTRL_REGWRITE);
   localparam logic [CW-1:0] C_BR = (16'(1) << CTRL_BRANCH) | (16'(2) << CTRL_ALUOP_LSB);

   vec_t vt[16];

   function automatic vec_t mk(input logic rst, fl, iv, ordy, input logic [DW-1:0] d,
                               input logic [CW-1:0] c, input logic [1:0] occ,
                               input logic irdy, ov, chk_d, input logic [DW-1:0] od,
                               input logic [CW-1:0] oc);
      vec_t v;
      v.rst = rst; v.fl = fl; v.iv = iv; v.ordy = ordy; v.d = d; v.c = c;
      v.occ = occ; v.irdy = irdy; v.ov = ov; v.chk_d = chk_d; v.od = od; v.oc = oc;
      return v;
   endfunction

   initial begin
      logic          pend_v;
      logic [DW-1:0] pend_d;
      logic [CW-1:0] pend_c;
      logic          fl, ordy, will_acc;

      //            rst fl iv rdy data   ctrl      occ irdy ov chkd od     oc
      vt[0]  = mk(1, 0, 1, 0, 32'h55, 16'hFFFF, 0, 1, 0, 1, 32'h0, 16'h0);
      vt[1]  = mk(0, 0, 1, 0, 32'hA,  C_MW,     1, 1, 1, 1, 32'hA, C_MW);
      vt[2]  = mk(0, 0, 1, 0, 32'hB,  C_LD,     2, 0, 1, 1, 32'hA, C_MW);
      vt[3]  = mk(0, 0, 0, 0, 32'h0,  16'h0,    2, 0, 1, 1, 32'hA, C_MW);
      vt[4]  = mk(0, 0, 0, 0, 32'h0,  16'h0,    2, 0, 1, 1, 32'hA, C_MW);
      vt[5]  = mk(0, 0, 0, 1, 32'h0,  16'h0,    1, 1, 1, 1, 32'hB, C_LD);
      vt[6]  = mk(0, 0, 0, 1, 32'h0,  16'h0,    0, 1, 0, 0, 32'h0, 16'h0);
      vt[7]  = mk(0, 0, 1, 0, 32'hA,  C_MW,     1, 1, 1, 1, 32'hA, C_MW);
      vt[8]  = mk(0, 0, 1, 0, 32'hB,  C_MW,     2, 0, 1, 1, 32'hA, C_MW);
      vt[9]  = mk(0, 1, 1, 0, 32'hC,  C_MW,     0, 1, 0, 0, 32'h0, 16'h0);
      vt[10] = mk(0, 0, 0, 1, 32'h0,  16'h0,    0, 1, 0, 0, 32'h0, 16'h0);
      vt[11] = mk(0, 0, 1, 0, 32'h1,  C_BR,     1, 1, 1, 1, 32'h1, C_BR);
      vt[12] = mk(0, 0, 1, 0, 32'h2,  C_MW,     2, 0, 1, 1, 32'h1, C_BR);
      vt[13] = mk(1, 1, 1, 0, 32'h3,  16'hFFFF, 0, 1, 0, 1, 32'h0, 16'h0);
      vt[14] = mk(0, 0, 0, 1, 32'h0,  16'h0,    0, 1, 0, 1, 32'h0, 16'h0);
      vt[15] = mk(0, 0, 0, 1, 32'h0,  16'h0,    0, 1, 0, 1, 32'h0, 16'h0);

      for (int i = 0; i < 16; i++) begin
         step(vt[i].rst, vt[i].fl, vt[i].iv, vt[i].ordy, vt[i].d, vt[i].c);
         chk("vec_occupancy", {30'd0, occupancy}, {30'd0, vt[i].occ});
         chk("vec_in_ready", {31'd0, in_ready}, {31'd0, vt[i].irdy});
         chk("vec_out_valid", {31'd0, out_valid}, {31'd0, vt[i].ov});
         chk("vec_out_ctrl", {16'd0, out_ctrl}, {16'd0, vt[i].oc});
         if (vt[i].chk_d) chk("vec_out_data", out_data, vt[i].od);
         $display("vec %0d: occ=%0d in_ready=%0b out_valid=%0b data=%h ctrl=%h",
                  i, occupancy, in_ready, out_valid, out_data, out_ctrl);
      end

      // Back-to-back streaming: head after each push must be that push.
      for (int i = 1; i <= 8; i++) begin
         step(0, 0, 1, 1, DW'(i), CW'(i));
         chk("stream_data", out_data, DW'(i));
         $display("stream push %0d: out_data=%h in_ready=%0b", i, out_data, in_ready);
      end
      step(0, 0, 0, 1, '0, '0);
      chk("stream_drained", {31'd0, out_valid}, 32'd0);

      // Randomized traffic with occasional flush; upstream holds offers until accepted.
      pend_v = 1'b0; pend_d = '0; pend_c = '0;
      for (int i = 0; i < 400; i++) begin
         if (!pend_v && $urandom_range(0, 3) != 0) begin
            pend_v = 1'b1;
            pend_d = $urandom;
            pend_c = CW'($urandom);
         end
         ordy     = ($urandom_range(0, 2) != 0);
         fl       = ($urandom_range(0, 39) == 0);
         will_acc = pend_v && (sb.size() != 2) && !fl;
         step(0, fl, pend_v, ordy, pend_d, pend_c);
         if (will_acc || fl) pend_v = 1'b0;
      end

`ifdef PIPE_STAGE_PERF_CNT_EN
      step(1, 0, 0, 0, '0, '0);
      chk("stall_cnt_reset", stall_cnt, 32'd0);
      chk("bubble_cnt_reset", bubble_cnt, 32'd0);
      step(0, 0, 1, 0, 32'h77, C_MW);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, '0, '0);
      step(0, 0, 0, 1, '0, '0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, '0, '0);
      chk("stall_cnt_5", stall_cnt, 32'd5);
      chk("bubble_cnt_3", bubble_cnt, 32'd3);
      chk("stall_cnt_model", stall_cnt, m_stall);
      step(0, 0, 1, 0, 32'h78, C_MW);
      force dut.stall_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.stall_cnt_q;
      m_stall = 32'hFFFF_FFFF;
      step(0, 0, 0, 0, '0, '0);
      chk("stall_cnt_sat", stall_cnt, 32'hFFFF_FFFF);
      step(0, 1, 0, 0, '0, '0);
      chk("stall_cnt_flush_keeps", stall_cnt, 32'hFFFF_FFFF);
      chk("bubble_cnt_flush_keeps", bubble_cnt, m_bubble);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
